// File: rtl/hdmi_pkg.sv
// Shared constants and types for the HDMI data island packet assembler.
// BCH polynomial, packet geometry and the subpacket type.
package hdmi_pkg;

    localparam logic [7:0] ECC_POLY = 8'h83;
    localparam int PACKET_CLOCKS = 32;
    localparam int HEADER_BITS = 24;
    localparam int SUB_BITS = 56;

    typedef logic [55:0] subpacket_t;

endpackage

// File: rtl/hdmi_bch_ecc_step.sv
// Combinational BCH parity step, LSB-first, BITS_PER_STEP bits per clock.
// parity_i: current parity; bits_i: bits in send order (bit 0 first); parity_o: next parity.
module hdmi_bch_ecc_step
    import hdmi_pkg::*;
#(
    parameter int BITS_PER_STEP = 1
) (
    input  logic [7:0]               parity_i,
    input  logic [BITS_PER_STEP-1:0] bits_i,
    output logic [7:0]               parity_o
);

    always_comb begin
        parity_o = parity_i;
        for (int i = 0; i < BITS_PER_STEP; i++) begin
            parity_o = (parity_o >> 1)
                     ^ ({8{bits_i[i] ^ parity_o[0]}} & ECC_POLY);
        end
    end

endmodule

// File: rtl/hdmi_packet_assembler.sv
// Latches one header + four subpackets per 32-clock slot, appends BCH parity
// and serialises to 9 data island bits per clock.
// Ports: clk_pixel, reset_n (async low), data_island_period, header[23:0],
//   sub[4][56] in; packet_start (comb pulse), packet_data[8:0], counter[4:0] out.
module hdmi_packet_assembler
    import hdmi_pkg::*;
(
    input  logic                   clk_pixel,
    input  logic                   reset_n,
    input  logic                   data_island_period,
    input  logic [HEADER_BITS-1:0] header,
    input  subpacket_t [3:0]       sub,
    output logic                   packet_start,
    output logic [8:0]             packet_data,
    output logic [4:0]             counter
);

    localparam logic [4:0] LAST_CLK = 5'(PACKET_CLOCKS - 1);
    localparam logic [4:0] HDR_CLKS = 5'(HEADER_BITS);
    localparam logic [4:0] SUB_CLKS = 5'(SUB_BITS / 2);

    logic [4:0]             cnt_q, cnt_d;
    logic [HEADER_BITS-1:0] hdr_q, hdr_d, hdr_cur;
    subpacket_t [3:0]       sub_q, sub_d, sub_cur;
    logic [7:0]             hdr_ecc_q, hdr_ecc_d, hdr_ecc_nx;
    logic [3:0][7:0]        sub_ecc_q, sub_ecc_d, sub_ecc_nx;
    logic [8:0]             pdata_q, pdata_d;
    logic [4:0]             cnt_out_q, cnt_out_d;
    logic                   start;
    logic                   hdr_bit;
    logic [3:0]             lo_bits, hi_bits;

    // Start cycle bypasses the latch so bit 0 uses the live inputs.
    always_comb begin
        start   = data_island_period && (cnt_q == 5'd0);
        hdr_cur = start ? header : hdr_q;
        sub_cur = start ? sub : sub_q;
    end

    always_comb begin
        hdr_bit = 1'b0;
        lo_bits = '0;
        hi_bits = '0;
        if (cnt_q < HDR_CLKS) begin
            hdr_bit = hdr_cur[cnt_q];
        end else begin
            hdr_bit = hdr_ecc_q[cnt_q[2:0]];
        end
        for (int k = 0; k < 4; k++) begin
            if (cnt_q < SUB_CLKS) begin
                lo_bits[k] = sub_cur[k][{cnt_q, 1'b0}];
                hi_bits[k] = sub_cur[k][{cnt_q, 1'b1}];
            end else begin
                lo_bits[k] = sub_ecc_q[k][{cnt_q[1:0], 1'b0}];
                hi_bits[k] = sub_ecc_q[k][{cnt_q[1:0], 1'b1}];
            end
        end
    end

    hdmi_bch_ecc_step #(
        .BITS_PER_STEP(1)
    ) u_hdr_ecc (
        .parity_i(hdr_ecc_q),
        .bits_i  (hdr_bit),
        .parity_o(hdr_ecc_nx)
    );

    for (genvar k = 0; k < 4; k++) begin : g_sub_ecc
        hdmi_bch_ecc_step #(
            .BITS_PER_STEP(2)
        ) u_sub_ecc (
            .parity_i(sub_ecc_q[k]),
            .bits_i  ({hi_bits[k], lo_bits[k]}),
            .parity_o(sub_ecc_nx[k])
        );
    end

    // Idle or wrap clears parity; an abandoned packet is simply dropped.
    always_comb begin
        cnt_d     = 5'd0;
        hdr_d     = hdr_q;
        sub_d     = sub_q;
        hdr_ecc_d = '0;
        sub_ecc_d = '0;
        pdata_d   = '0;
        cnt_out_d = '0;
        if (data_island_period) begin
            cnt_d     = (cnt_q == LAST_CLK) ? 5'd0 : cnt_q + 5'd1;
            pdata_d   = {hi_bits, lo_bits, hdr_bit};
            cnt_out_d = cnt_q;
            if (start) begin
                hdr_d = header;
                sub_d = sub;
            end
            if (cnt_q != LAST_CLK) begin
                hdr_ecc_d = (cnt_q < HDR_CLKS) ? hdr_ecc_nx : hdr_ecc_q;
                sub_ecc_d = (cnt_q < SUB_CLKS) ? sub_ecc_nx : sub_ecc_q;
            end
        end
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            hdr_q     <= '0;
            sub_q     <= '0;
            hdr_ecc_q <= '0;
            sub_ecc_q <= '0;
            pdata_q   <= '0;
            cnt_out_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            hdr_q     <= hdr_d;
            sub_q     <= sub_d;
            hdr_ecc_q <= hdr_ecc_d;
            sub_ecc_q <= sub_ecc_d;
            pdata_q   <= pdata_d;
            cnt_out_q <= cnt_out_d;
        end
    end

    assign packet_start = start & reset_n;
    assign packet_data  = pdata_q;
    assign counter      = cnt_out_q;

endmodule

// File: doc/hdmi_packet_assembler.md
Name: hdmi_packet_assembler

Overview:
Downstream consumer of the audio clock regeneration packet and of every other data island packet source (null, audio sample, infoframes).
- Latches one 24-bit header and four 56-bit subpackets at the start of each packet slot.
- Appends BCH parity: ECC byte on the header (BCH(32,24)), ECC byte on each subpacket (BCH(64,56)).
- Serialises the 32-clock packet into the 9 per-clock data-island bits consumed by the TERC4 encoder.

Parameters:
- ECC_POLY, 8'h83, reflected BCH generator x^8+x^7+x^6+1, applied LSB-first.
- PACKET_CLOCKS, 32, pixel clocks per packet (fixed by HDMI 1.4b 5.2.3.4; not intended to change).

Ports:
- clk_pixel  in  1  pixel clock; only clock.
- reset_n  in  1  asynchronous, active-low reset.
- data_island_period  in  1  high during data island packet clocks (excludes guard bands and preambles).
- header  in  24  packet header HB2:HB1:HB0, HB0 in [7:0].
- sub  in  4x56  subpackets 0..3, SB0 in [7:0].
- packet_start  out  1  one-cycle pulse when a packet is latched; the upstream picker advances its selection on it.
- packet_data  out  9  [0] = ch0 bit2 (header bit); [4:1] = ch1 data; [8:5] = ch2 data.
- counter  out  5  bit index of the bit pair currently presented on packet_data.

Behaviour:
- Reset: counter=0, packet_data=0, packet_start=0, latched header/sub=0, all five parity registers=0. Async assert, sync-safe deassert.
- Idle (data_island_period=0):
  - counter held at 0; parity registers cleared; packet_data=0; packet_start=0.
  - A packet abandoned mid-way (period drops early) is discarded, not resumed.
- Cycle with data_island_period=1 and counter==0:
  - Latch header/sub.
  - Pulse packet_start for exactly this cycle.
  - Emit bit 0 using the freshly latched values; the mux bypasses the latch on this cycle.
- Each cycle with data_island_period=1: emit bit index c=counter, then counter <= c+1 mod 32. At 31 it wraps to 0, so back-to-back packets latch on the next cycle with no gap.
- Header lane, packet_data[0]:
  - c<24: header[c].
  - c>=24: hdr_ecc[c-24].
  - hdr_ecc is updated LSB-first with each header bit emitted for c<24.
- Subpacket lanes, k=0..3:
  - packet_data[1+k] = bit 2c of subpacket k.
  - packet_data[5+k] = bit 2c+1 of subpacket k.
  - For c<28 these are sub[k][2c] / sub[k][2c+1].
  - For c>=28 they are sub_ecc[k][2(c-28)] / sub_ecc[k][2(c-28)+1].
  - sub_ecc[k] steps two bits per clock for c<28.
- ECC step, per input bit b: p <= (p>>1) ^ ({8{b ^ p[0]}} & ECC_POLY).
- Parity registers are cleared when counter wraps to 0, so each packet starts from 0.
- packet_data is registered: bit index c appears on packet_data the cycle after the counter==c cycle. Upstream TERC4 timing allows for this one-clock latency. counter is presented with the same one-clock alignment.
- Upstream inputs may change at any time; only the values sampled on the packet_start cycle are used.
- Simultaneous events:
  - packet_start and the period ending on the same cycle: still latches, then the packet is abandoned.
  - reset_n low mid-packet: immediate return to reset state.

Decomposition:
- hdmi_pkg holds ECC_POLY, PACKET_CLOCKS, HEADER_BITS=24, SUB_BITS=56, and typedef subpacket_t = logic [55:0].
- One natural sub-module: hdmi_bch_ecc_step. It is combinational and parameterised by BITS_PER_STEP (1 for header, 2 for subpackets). It is instantiated 5 times.

Test Plan:
- All-zero header/sub (null packet), 32-clock period: packet_start pulses once; all 32 packet_data words = 9'h000; all ECC bytes = 0.
- ACR packet with header 24'h000001, sub = {N=6144, CTS=25200}: data[0] = 1 on the first output clock, 0 for clocks 1..23. Clocks 24..31 match the bench model's ECC. Subpacket bit pairs match the model on every clock.
- Single bit header[0]=1, else 0: hdr_ecc = 8'h83 shifted through 23 zero steps. Compare all 8 ECC bits on clocks 24..31 against the model.
- 64-clock period, two different packets: packet_start pulses on clocks 0 and 32; second packet's ECC is uncorrupted (parity cleared at wrap).
- Period drops at clock 10, then reasserts: new packet_start, counter restarts at 0, output matches a fresh packet.
- reset_n asserted at clock 15: outputs go to 0 asynchronously; after release, the next period starts a clean packet.
